// File: rtl/pong_match_ctrl_if.sv
// Pong match controller bus: player/game-core inputs and match status outputs.
// master drives start/pause/miss1/miss2; slave (the controller) drives the rest.
interface pong_match_ctrl_if;
    logic       start;
    logic       pause;
    logic       miss1;
    logic       miss2;
    logic       game_en;
    logic       ball_serve;
    logic       serve_dir;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [1:0] winner;
    logic [2:0] state;

    modport master (
        output start, pause, miss1, miss2,
        input  game_en, ball_serve, serve_dir,
        input  score1, score2, winner, state
    );

    modport slave (
        input  start, pause, miss1, miss2,
        output game_en, ball_serve, serve_dir,
        output score1, score2, winner, state
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve delay, play tick divider, scoring, win detect.
// Ports: clk, reset (sync, active-high), bus (slave): start/pause/miss in, status out.
module pong_match_ctrl #(
    parameter int SERVE_DELAY = 64,
    parameter int TICK_DIV    = 4,
    parameter int WIN_SCORE   = 7
) (
    input  logic clk,
    input  logic reset,
    pong_match_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_DELAY - 1);
    localparam logic [7:0] DIV_LAST   = 8'(TICK_DIV - 1);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);

    state_t     st;
    logic [7:0] cnt;
    logic [7:0] div;
    logic [7:0] div_nxt;
    logic       game_en_q;
    logic       ball_serve_q;
    logic       serve_dir_q;
    logic [3:0] score1_q;
    logic [3:0] score2_q;
    logic [1:0] winner_q;

    // game_en is registered against the divider value it will hold next,
    // so the pulse lines up with the cycle where div == TICK_DIV-1.
    assign div_nxt = (div == DIV_LAST) ? 8'd0 : div + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            st           <= IDLE;
            cnt          <= '0;
            div          <= '0;
            game_en_q    <= 1'b0;
            ball_serve_q <= 1'b0;
            serve_dir_q  <= 1'b0;
            score1_q     <= '0;
            score2_q     <= '0;
            winner_q     <= '0;
        end else begin
            game_en_q    <= 1'b0;
            ball_serve_q <= 1'b0;
            unique case (st)
                IDLE, OVER: begin
                    if (bus.start) begin
                        st           <= SERVE;
                        cnt          <= '0;
                        ball_serve_q <= 1'b1;
                        score1_q     <= '0;
                        score2_q     <= '0;
                        winner_q     <= '0;
                        serve_dir_q  <= 1'b0;
                    end
                end
                SERVE: begin
                    if (cnt == SERVE_LAST) begin
                        st        <= PLAY;
                        cnt       <= '0;
                        div       <= '0;
                        game_en_q <= (DIV_LAST == 8'd0);
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                PLAY: begin
                    if (bus.pause) begin
                        div <= div;
                    end else if (bus.miss1 && bus.miss2) begin
                        st <= POINT;
                    end else if (bus.miss1) begin
                        score2_q    <= score2_q + 4'd1;
                        serve_dir_q <= 1'b0;
                        st          <= POINT;
                    end else if (bus.miss2) begin
                        score1_q    <= score1_q + 4'd1;
                        serve_dir_q <= 1'b1;
                        st          <= POINT;
                    end else begin
                        div       <= div_nxt;
                        game_en_q <= (div_nxt == DIV_LAST);
                    end
                end
                POINT: begin
                    if (score1_q == WIN) begin
                        winner_q <= 2'd1;
                        st       <= OVER;
                    end else if (score2_q == WIN) begin
                        winner_q <= 2'd2;
                        st       <= OVER;
                    end else begin
                        st           <= SERVE;
                        cnt          <= '0;
                        ball_serve_q <= 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.game_en    = game_en_q;
    assign bus.ball_serve = ball_serve_q;
    assign bus.serve_dir  = serve_dir_q;
    assign bus.score1     = score1_q;
    assign bus.score2     = score2_q;
    assign bus.winner     = winner_q;
    assign bus.state      = st;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl (SERVE_DELAY=4, TICK_DIV=2, WIN_SCORE=3).
// Vector table for the main match flow plus hand sequences for reset and win.
module tb_pong_match_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pong_match_ctrl_if bus();

    pong_match_ctrl #(
        .SERVE_DELAY(4),
        .TICK_DIV(2),
        .WIN_SCORE(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic       rst, start, pause, m1, m2;
        logic [2:0] st;
        logic [3:0] s1, s2;
        logic       dir;
        logic [1:0] win;
        logic       ge, bs;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, st_in, pa, m1, m2,
                       input logic [2:0] st, input logic [3:0] s1, s2,
                       input logic dir, input logic [1:0] win,
                       input logic ge, bs);
        vec_t v;
        v.rst = rst; v.start = st_in; v.pause = pa; v.m1 = m1; v.m2 = m2;
        v.st = st; v.s1 = s1; v.s2 = s2; v.dir = dir; v.win = win;
        v.ge = ge; v.bs = bs;
        vq.push_back(v);
    endtask

    task automatic tick(input logic rst, st_in, pa, m1, m2);
        @(negedge clk);
        reset     = rst;
        bus.start = st_in;
        bus.pause = pa;
        bus.miss1 = m1;
        bus.miss2 = m2;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pk(input logic [2:0] st,
                                       input logic [3:0] s1, s2,
                                       input logic dir,
                                       input logic [1:0] win,
                                       input logic ge, bs);
        return {st, s1, s2, dir, win, ge, bs};
    endfunction

    function automatic logic [15:0] act();
        return pk(bus.state, bus.score1, bus.score2, bus.serve_dir,
                  bus.winner, bus.game_en, bus.ball_serve);
    endfunction

    task automatic chk(input string name, input logic [15:0] exp);
        logic [15:0] a;
        a = act();
        checks++;
        if (a !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d s1=%0d s2=%0d dir=%0d win=%0d ge=%0d bs=%0d, want st=%0d s1=%0d s2=%0d dir=%0d win=%0d ge=%0d bs=%0d",
                     name, a[15:13], a[12:9], a[8:5], a[4], a[3:2], a[1], a[0],
                     exp[15:13], exp[12:9], exp[8:5], exp[4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic wait_play(input string name);
        int n;
        n = 0;
        while (bus.state !== 3'd2 && n < 20) begin
            tick(0, 0, 0, 0, 0);
            n++;
        end
        if (bus.state !== 3'd2) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for PLAY, state=%0d", name, bus.state);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 0; bus.pause = 0; bus.miss1 = 0; bus.miss2 = 0;

        //  rst st pa m1 m2   st s1 s2 dir win ge bs
        add(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0); // reset
        add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0); // idle
        add(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0); // miss in idle
        add(0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1); // start -> serve
        add(0, 1, 0, 1, 0,   1, 0, 0, 0, 0, 0, 0); // start/miss ignored
        add(0, 0, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0); // pause no stall
        add(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0); // play
        add(0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1,   3, 1, 0, 1, 0, 0, 0); // miss2
        add(0, 0, 0, 0, 0,   1, 1, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0,   1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,   1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,   1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,   2, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0,   3, 1, 1, 0, 0, 0, 0); // miss1
        add(0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   2, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1,   3, 1, 1, 0, 0, 0, 0); // both miss
        add(0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   2, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   2, 1, 1, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0,   2, 1, 1, 0, 0, 0, 0); // pause x5
        add(0, 0, 1, 1, 0,   2, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1,   2, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0,   2, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0,   2, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   2, 1, 1, 0, 0, 0, 0); // resume
        add(0, 0, 0, 0, 0,   2, 1, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0,   2, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0,   3, 1, 2, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   1, 1, 2, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0,   1, 1, 2, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   1, 1, 2, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   1, 1, 2, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   2, 1, 2, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0,   3, 1, 3, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   4, 1, 3, 0, 2, 0, 0); // over, p2
        add(0, 0, 0, 1, 1,   4, 1, 3, 0, 2, 0, 0);
        add(0, 0, 1, 0, 0,   4, 1, 3, 0, 2, 0, 0);
        add(0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1); // restart

        foreach (vq[i]) begin
            tick(vq[i].rst, vq[i].start, vq[i].pause, vq[i].m1, vq[i].m2);
            chk($sformatf("vec%0d", i),
                pk(vq[i].st, vq[i].s1, vq[i].s2, vq[i].dir,
                   vq[i].win, vq[i].ge, vq[i].bs));
        end

        // score1 to 2, then reset mid-PLAY with every input active
        wait_play("play_a");
        tick(0, 0, 0, 0, 1);
        chk("s1_one", pk(3, 1, 0, 1, 0, 0, 0));
        wait_play("play_b");
        tick(0, 0, 0, 0, 1);
        chk("s1_two", pk(3, 2, 0, 1, 0, 0, 0));
        wait_play("play_c");
        tick(0, 0, 0, 0, 0);
        tick(1, 1, 1, 1, 1);
        chk("rst_mid_play", pk(0, 0, 0, 0, 0, 0, 0));
        tick(0, 0, 0, 0, 0);
        chk("idle_after_rst", pk(0, 0, 0, 0, 0, 0, 0));

        // reset mid-SERVE
        tick(0, 1, 0, 0, 0);
        chk("serve_again", pk(1, 0, 0, 0, 0, 0, 1));
        tick(1, 0, 0, 0, 0);
        chk("rst_mid_serve", pk(0, 0, 0, 0, 0, 0, 0));

        // player 1 wins
        tick(0, 1, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            wait_play($sformatf("play_w%0d", k));
            tick(0, 0, 0, 0, 1);
            chk($sformatf("p1_pt%0d", k), pk(3, 4'(k), 0, 1, 0, 0, 0));
        end
        tick(0, 0, 0, 0, 0);
        chk("p1_wins", pk(4, 3, 0, 1, 1, 0, 0));
        tick(0, 0, 0, 1, 0);
        chk("over_hold", pk(4, 3, 0, 1, 1, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  SERVE_DELAY  64  cycles spent in SERVE before play resumes, legal range 1..255
  TICK_DIV  4  clock cycles per game_en pulse in PLAY, legal range 1..255
  WIN_SCORE  7  points that end the match, legal range 1..15
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  input  1  sole clock, rising-edge
  reset  input  1  synchronous, active-high
  start  input  1  level; begins a match from IDLE or OVER
  pause  input  1  level; freezes play while high
  miss1  input  1  single-cycle pulse from game core: ball passed paddle1 (left)
  miss2  input  1  single-cycle pulse from game core: ball passed paddle2 (right)
  game_en  output  1  single-cycle tick enabling one game-core update
  ball_serve  output  1  single-cycle pulse: core re-centres ball and paddles
  serve_dir  output  1  initial ball direction, 0 = toward paddle1, 1 = toward paddle2
  score1  output  4  points won by player 1
  score2  output  4  points won by player 2
  winner  output  2  0 none, 1 player 1, 2 player 2
  state  output  3  FSM state: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
REQ-003 All outputs SHALL be registered.

Function
REQ-004 IDLE: game_en=0; start=1 -> SERVE next cycle; scores cleared to 0, serve_dir=0.
REQ-005 ball_serve SHALL be high exactly during the first cycle of every SERVE visit and low otherwise.
REQ-006 SERVE: internal counter starts at 0 on entry, increments each cycle; at count SERVE_DELAY-1 -> PLAY next cycle (SERVE lasts exactly SERVE_DELAY cycles); pause does not stall SERVE.
REQ-007 PLAY: tick divider starts at 0 on entry; game_en high for one cycle when divider = TICK_DIV-1, divider then wraps to 0; TICK_DIV=1 -> game_en high every PLAY cycle.
REQ-008 PLAY with pause=1: divider holds, game_en=0, miss1/miss2 ignored; resume continues from held divider value.
REQ-009 PLAY, pause=0, miss1=1 only: score2 incremented on same edge, serve_dir<=0 (next serve toward the conceding player), -> POINT.
REQ-010 PLAY, pause=0, miss2=1 only: score1 incremented on same edge, serve_dir<=1, -> POINT.
REQ-011 miss1 and miss2 both high same cycle: no score change, serve_dir unchanged, -> POINT (re-serve).
REQ-012 miss1/miss2 SHALL be ignored in every state other than PLAY.
REQ-013 POINT lasts exactly one cycle, game_en=0; if score1=WIN_SCORE -> winner<=1, -> OVER; else if score2=WIN_SCORE -> winner<=2, -> OVER; else -> SERVE.
REQ-014 Scores SHALL never exceed WIN_SCORE; no wrap is reachable.
REQ-015 OVER: game_en=0, scores and winner held; start=1 -> scores<=0, winner<=0, serve_dir<=0, -> SERVE.
REQ-016 start SHALL be ignored in SERVE, PLAY and POINT.
REQ-017 Latency: miss pulse at edge N -> updated score visible after edge N; ball_serve of next serve at cycle N+2.

Reset
REQ-018 reset=1 at a rising edge SHALL force, in any state including mid-SERVE/PLAY: state=IDLE, game_en=0, ball_serve=0, serve_dir=0, score1=0, score2=0, winner=0, all counters 0.
REQ-019 reset SHALL take priority over start, pause, miss1, miss2.

Verification (SERVE_DELAY=4, TICK_DIV=2, WIN_SCORE=3)
REQ-020 Reset then start pulse -> state 1 next cycle, ball_serve high one cycle, state 2 exactly 4 cycles later, then game_en toggling 0,1,0,1.
REQ-021 In PLAY, miss2 pulse -> score1=1, serve_dir=1, state 3 one cycle, state 1 with ball_serve next; repeat with miss1 -> score2=1, serve_dir=0.
REQ-022 Three miss1 pulses across serves -> score2=3, winner=2, state 4; further miss/start-less cycles leave all outputs unchanged; start -> scores 0, winner 0, state 1.
REQ-023 miss1 and miss2 same cycle in PLAY -> scores unchanged, state 3 then 1; miss pulses during SERVE/pause -> no score change.
REQ-024 pause high 5 cycles in PLAY -> game_en 0 throughout, divider held; reset asserted mid-PLAY with score1=2 -> all outputs at reset values next cycle.
